edge_detect_h: RTL
==================

Name: edge_detect_h

Overview:
- Avalon-ST video stage placed directly upstream of the edge-bins stage.
- Converts each 24-bit RGB pixel to 8-bit grey and computes the horizontal backward gradient |Y[x] − Y[x−1]|.
- Thresholds that gradient and emits binary edge pixels: 24'd255 for an edge, 0 otherwise. This is the exact format the bins stage counts.
- An Avalon-MM slave exposes enable, threshold and frame statistics.

Parameters:
- IMG_WIDTH, 640, pixels per line; the column counter wraps here.
- THRESH_DEFAULT, 40, reset value of the threshold register.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- sink_data  in  24  RGB pixel {R[23:16],G[15:8],B[7:0]}, or packet header
- sink_valid  in  1  sink beat valid
- sink_ready  out  1  sink may accept
- sink_sop  in  1  start of packet (header beat)
- sink_eop  in  1  end of packet
- source_data  out  24  processed pixel or passed-through beat
- source_valid  out  1  source beat valid
- source_ready  in  1  downstream ready
- source_sop  out  1  start of packet
- source_eop  out  1  end of packet
- s_chipselect  in  1  MM select
- s_read  in  1  MM read
- s_write  in  1  MM write
- s_address  in  3  register index
- s_writedata  in  32  write data
- s_readdata  out  32  read data, registered

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high.
- Handshake:
  - Ready latency 0; sink_ready = source_ready (combinational).
  - Beat accepted when sink_valid && sink_ready.
  - Two-stage pipeline with per-stage valid. The whole pipeline advances only when source_ready = 1 and holds otherwise; no beat is lost or duplicated.
- Latency: 2 cycles from accepted beat to source_valid while source_ready = 1.
- Packets:
  - The beat carrying sink_sop is the header; data[3:0] is the packet type. Type 0 = video, anything else = non-video.
  - The header beat passes through unchanged.
  - All beats of a non-video packet pass through unchanged.
  - sop/eop are delayed with their beat.
- Video pixel beats (every beat after the header, including the eop beat):
  - Stage 1: Y = (R + 2G + B) >> 2, computed with a 10-bit intermediate.
  - Stage 2: diff = |Y − Yprev| (8-bit). Output is 24'd255 if diff > thr, else 0.
  - Yprev updates on every processed video pixel.
- Column counter:
  - Cleared to 0 at the header beat; increments per video pixel; wraps from IMG_WIDTH−1 to 0.
  - At column 0 the output is forced to 0 (no left neighbour).
- Threshold (thr):
  - Internal thr is loaded from the THRESH register at each header beat, so a mid-frame write takes effect at the next packet.
- Enable:
  - When ENABLE = 0, video pixels pass through unchanged.
  - Latency stays 2 cycles; counters still run.
- Statistics:
  - Edge counter cleared at a video header, +1 per edge output.
  - At a video eop: EDGES ← counter, FRAMES ← FRAMES + 1 (wraps at 32 bits).
- Register map (s_readdata registered, 1-cycle latency, unmapped addresses read 0):
  - 0 CTRL: bit0 ENABLE (reset 1), bit1 OVERLAY.
  - 1 THRESH: [7:0], reset THRESH_DEFAULT.
  - 2 FRAMES: read-only.
  - 3 EDGES: read-only.
  - Writes to read-only registers are ignored.
- Reset values: source_valid 0, source_sop/eop/data 0, s_readdata 0, all pipeline valids 0, counters 0.
  - Reset mid-packet discards in-flight beats.
  - After reset, beats are treated as non-video until the next sop.

Optional Feature:
- Macro: EDGE_DETECT_OVERLAY_EN.
- Defined:
  - CTRL bit1 is writable (reset 0).
  - When bit1 = 1 and ENABLE = 1, edge pixels output 24'hFF0000 and non-edge pixels output the original RGB, carried through the pipeline.
  - The edge counter behaves the same either way.
- Undefined: bit1 is read-only 0 and there is no RGB pipeline register.

Decomposition:
- Package edge_detect_pkg:
  - Register address constants.
  - Packet type constant PKT_VIDEO = 4'h0.
  - EDGE_PIXEL = 24'd255, OVERLAY_PIXEL = 24'hFF0000.
  - Pixel typedef (struct r, g, b).
- Sub-module rgb_to_grey: combinational luma plus stage-1 register.

Test Plan:
- Reset → source_valid 0. Read addr 1 → 0x28; addr 0 → 0x1; addr 2 → 0.
- Video frame, 640×480: header type 0, pixel 24'hFFFFFF at columns 31–32, else 0, thr 40. Required output:
  - Header unchanged.
  - 24'd255 at columns 31 and 33 of every line, 0 elsewhere.
  - After eop: EDGES = 0x3C0, FRAMES = 1.
- Column-0 case: column 639 white, next line column 0 black → column 0 outputs 0, not 255.
- Backpressure: source_ready pattern 1,0,1,1,0 during the frame above → output beat sequence identical to the unstalled run; sink_ready mirrors source_ready every cycle.
- Non-video packet: header data[3:0] = 0xF, 4 beats of 0x123456 → all passed unchanged; FRAMES and EDGES unchanged.
- Threshold and enable:
  - Write THRESH = 0xFF mid-frame → current frame still uses thr 40; next frame has 0 edges.
  - Write CTRL = 0 → video pixels pass unchanged with 2-cycle latency.

Source files
------------

// File: rtl/edge_detect_pkg.sv
// Shared definitions for the horizontal edge-detect video stage:
// register map, packet type codes, output pixel codes and the luma helper.
package edge_detect_pkg;

  localparam logic [2:0] ADDR_CTRL   = 3'd0;
  localparam logic [2:0] ADDR_THRESH = 3'd1;
  localparam logic [2:0] ADDR_FRAMES = 3'd2;
  localparam logic [2:0] ADDR_EDGES  = 3'd3;

  localparam logic [3:0] PKT_VIDEO = 4'h0;

  localparam logic [23:0] EDGE_PIXEL    = 24'd255;
  localparam logic [23:0] OVERLAY_PIXEL = 24'hFF0000;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

  // Y = (R + 2G + B) >> 2; the sum peaks at 1020, so 10 bits never overflow.
  function automatic logic [7:0] luma(input pixel_t p);
    logic [9:0] sum;
    sum = {2'b00, p.r} + {1'b0, p.g, 1'b0} + {2'b00, p.b};
    return sum[9:2];
  endfunction

endpackage

// File: rtl/rgb_to_grey.sv
// First pipeline stage: converts the incoming RGB beat to 8-bit grey and
// registers it together with the original beat and its packet markers.
module rgb_to_grey
  import edge_detect_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        advance,
  input  logic        beat_valid,
  input  logic [23:0] beat_data,
  input  logic        beat_sop,
  input  logic        beat_eop,
  input  logic        beat_video_hdr,
  input  logic        beat_pixel,
  output logic        stage_valid,
  output logic [23:0] stage_data,
  output logic        stage_sop,
  output logic        stage_eop,
  output logic        stage_video_hdr,
  output logic        stage_pixel,
  output logic [7:0]  stage_y
);

  logic [7:0] y_next;

  assign y_next = luma(pixel_t'(beat_data));

  // Stage-1 register; markers are gated with valid so an empty slot never looks like a beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_valid     <= 1'b0;
      stage_data      <= '0;
      stage_sop       <= 1'b0;
      stage_eop       <= 1'b0;
      stage_video_hdr <= 1'b0;
      stage_pixel     <= 1'b0;
      stage_y         <= '0;
    end else if (advance) begin
      stage_valid     <= beat_valid;
      stage_data      <= beat_data;
      stage_sop       <= beat_valid & beat_sop;
      stage_eop       <= beat_valid & beat_eop;
      stage_video_hdr <= beat_valid & beat_video_hdr;
      stage_pixel     <= beat_valid & beat_pixel;
      stage_y         <= y_next;
    end
  end

endmodule

// File: rtl/edge_detect_h.sv
// Horizontal edge detector for an Avalon-ST video stream: grey conversion,
// backward gradient against the previous pixel, threshold to binary edge
// pixels, plus an Avalon-MM register block for enable, threshold and stats.
// Optional build macro EDGE_DETECT_OVERLAY_EN adds the CTRL overlay bit,
// which paints edges red over the original image instead of binary output.
module edge_detect_h
  import edge_detect_pkg::*;
#(
  parameter int         IMG_WIDTH      = 640,
  parameter logic [7:0] THRESH_DEFAULT = 8'd40
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] sink_data,
  input  logic        sink_valid,
  output logic        sink_ready,
  input  logic        sink_sop,
  input  logic        sink_eop,
  output logic [23:0] source_data,
  output logic        source_valid,
  input  logic        source_ready,
  output logic        source_sop,
  output logic        source_eop,
  input  logic        s_chipselect,
  input  logic        s_read,
  input  logic        s_write,
  input  logic [2:0]  s_address,
  input  logic [31:0] s_writedata,
  output logic [31:0] s_readdata
);

  localparam int COL_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);

  logic             advance;
  logic             accept;
  logic             in_video;
  logic             beat_video_hdr;
  logic             beat_pixel;

  logic             s1_valid;
  logic [23:0]      s1_data;
  logic             s1_sop;
  logic             s1_eop;
  logic             s1_video_hdr;
  logic             s1_pixel;
  logic [7:0]       s1_y;

  logic [7:0]       thr;
  logic [COL_W-1:0] col;
  logic [7:0]       y_prev;
  logic [31:0]      edge_cnt;

  logic             ctrl_enable;
  logic             overlay_bit;
  logic [7:0]       thresh_reg;
  logic [31:0]      frames_reg;
  logic [31:0]      edges_reg;
  logic [31:0]      read_mux;

  logic [7:0]       diff;
  logic             is_edge;
  logic [23:0]      out_data;
  logic             unused_wdata;

  assign advance        = source_ready;
  assign sink_ready     = source_ready;
  assign accept         = sink_valid & source_ready;
  assign beat_video_hdr = sink_sop & (sink_data[3:0] == PKT_VIDEO);
  assign beat_pixel     = ~sink_sop & in_video;
  assign unused_wdata   = ^s_writedata[31:8];

  // Tracks whether the current packet is video; anything without a video header is passed through.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_video <= 1'b0;
    end else if (accept) begin
      if (sink_sop) begin
        in_video <= beat_video_hdr;
      end else if (sink_eop) begin
        in_video <= 1'b0;
      end
    end
  end

  rgb_to_grey u_rgb_to_grey (
    .clk             (clk),
    .reset           (reset),
    .advance         (advance),
    .beat_valid      (sink_valid),
    .beat_data       (sink_data),
    .beat_sop        (sink_sop),
    .beat_eop        (sink_eop),
    .beat_video_hdr  (beat_video_hdr),
    .beat_pixel      (beat_pixel),
    .stage_valid     (s1_valid),
    .stage_data      (s1_data),
    .stage_sop       (s1_sop),
    .stage_eop       (s1_eop),
    .stage_video_hdr (s1_video_hdr),
    .stage_pixel     (s1_pixel),
    .stage_y         (s1_y)
  );

`ifdef EDGE_DETECT_OVERLAY_EN
  logic ctrl_overlay;
  assign overlay_bit = ctrl_overlay;
`else
  assign overlay_bit = 1'b0;
`endif

  // Gradient, edge decision and output pixel selection for the beat leaving stage 1.
  always_comb begin
    diff     = (s1_y >= y_prev) ? (s1_y - y_prev) : (y_prev - s1_y);
    is_edge  = s1_pixel && (col != '0) && (diff > thr);
    out_data = s1_data;
    if (s1_pixel && ctrl_enable) begin
      if (overlay_bit) begin
        out_data = is_edge ? OVERLAY_PIXEL : s1_data;
      end else begin
        out_data = is_edge ? EDGE_PIXEL : 24'd0;
      end
    end
  end

  // Stage-2 output register plus the per-line and per-frame bookkeeping that moves with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      source_valid <= 1'b0;
      source_sop   <= 1'b0;
      source_eop   <= 1'b0;
      source_data  <= '0;
      thr          <= THRESH_DEFAULT;
      col          <= '0;
      y_prev       <= '0;
      edge_cnt     <= '0;
      frames_reg   <= '0;
      edges_reg    <= '0;
    end else if (advance) begin
      source_valid <= s1_valid;
      source_sop   <= s1_sop;
      source_eop   <= s1_eop;
      source_data  <= out_data;
      if (s1_sop) begin
        col <= '0;
        thr <= thresh_reg;
        if (s1_video_hdr) begin
          edge_cnt <= '0;
        end
      end else if (s1_pixel) begin
        y_prev   <= s1_y;
        col      <= (col == COL_LAST) ? '0 : col + COL_W'(1);
        edge_cnt <= edge_cnt + 32'(is_edge);
        if (s1_eop) begin
          edges_reg  <= edge_cnt + 32'(is_edge);
          frames_reg <= frames_reg + 32'd1;
        end
      end
    end
  end

  // Register read multiplexer; unmapped addresses read as zero.
  always_comb begin
    read_mux = '0;
    case (s_address)
      ADDR_CTRL:   read_mux = {30'd0, overlay_bit, ctrl_enable};
      ADDR_THRESH: read_mux = {24'd0, thresh_reg};
      ADDR_FRAMES: read_mux = frames_reg;
      ADDR_EDGES:  read_mux = edges_reg;
      default:     read_mux = '0;
    endcase
  end

  // Writable control registers and the registered read data port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_enable <= 1'b1;
`ifdef EDGE_DETECT_OVERLAY_EN
      ctrl_overlay <= 1'b0;
`endif
      thresh_reg  <= THRESH_DEFAULT;
      s_readdata  <= '0;
    end else begin
      if (s_chipselect && s_write) begin
        case (s_address)
          ADDR_CTRL: begin
            ctrl_enable <= s_writedata[0];
`ifdef EDGE_DETECT_OVERLAY_EN
            ctrl_overlay <= s_writedata[1];
`endif
          end
          ADDR_THRESH: thresh_reg <= s_writedata[7:0];
          default: ;
        endcase
      end
      if (s_chipselect && s_read) begin
        s_readdata <= read_mux;
      end
    end
  end

endmodule
